uart_rx_oversampled: RTL and testbench

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx_oversampled.sv | 141 ++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame constants,
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int OVS_DEF     = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. The reset value is a
// parameter so an idle-high line can be held at 1 through reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver. The line is synchronized, the start bit is
// qualified at its midpoint, then each data bit and the stop bit are sampled
// one full bit period (OVS ticks) apart.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | line idle, waiting for rx_s low (no tick needed to leave)
//   START | counting to the start-bit midpoint, rejecting glitches
//   DATA  | shifting in DBIT data bits, LSB first
//   STOP  | waiting SB_TICK ticks, then publishing dout / frame_error
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int OVS     = OVS_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_error
);

    localparam int SMAX = max_int(OVS, SB_TICK);
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic rx_s;

    uart_state_e     state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic [DBIT-1:0] dout_next;
    logic            done_next;
    logic            fe_next;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            frame_error  <= fe_next;
        end
    end

    // Next-state and datapath update; everything except the IDLE exit waits for s_tick
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        dout_next  = dout;
        fe_next    = frame_error;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s == S_HALF) begin
                        if (!rx_s) begin
                            s_next     = '0;
                            n_next     = '0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        state_next = IDLE;
                        dout_next  = b;
                        done_next  = 1'b1;
                        fe_next    = ~rx_s;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: a serial driver pushes the
// expected word/frame_error into a scoreboard, and a monitor pops and
// compares on every rx_done_tick.
module tb_uart_rx_oversampled;
    import uart_pkg::*;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int OVS     = 16;
    // 2 sync flops + 1 IDLE detect + half start bit + data bits + stop ticks
    localparam int LAT_FULL = 3 + OVS / 2 + DBIT * OVS + SB_TICK;

    typedef struct {
        logic [7:0] data;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_error;

    int tests = 0;
    int fails = 0;

    exp_t sb_q[$];
    int   done_cyc[$];
    int   cyc = 0;
    int   total_done = 0;

    bit         tick_mode = 1'b0;
    logic [1:0] mod_cnt = 2'd0;

    uart_rx_oversampled #(.DBIT(DBIT), .SB_TICK(SB_TICK), .OVS(OVS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_error  (frame_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Modulus-4 tick generator, standing in for the baud tick generator
    always @(posedge clk) mod_cnt <= (mod_cnt == 2'd3) ? 2'd0 : mod_cnt + 2'd1;
    assign s_tick = tick_mode ? (mod_cnt == 2'd3) : 1'b1;

    // Scoreboard monitor
    logic [7:0] prev_dout = '0;
    logic       prev_fe = 1'b0;
    logic       prev_done = 1'b0;
    bit         out_changed = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (!rx_done_tick && (dout !== prev_dout || frame_error !== prev_fe))
                out_changed = 1'b1;
            if (rx_done_tick) begin
                total_done++;
                done_cyc.push_back(cyc);
                tests++;
                if (prev_done) begin
                    fails++;
                    $display("FAIL done_width: rx_done_tick high 2 cycles, required 1");
                end
                tests++;
                if (out_changed) begin
                    fails++;
                    $display("FAIL out_stable: dout/frame_error changed without rx_done_tick");
                end
                out_changed = 1'b0;
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: dout=%h fe=%b, no frame expected", dout, frame_error);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (dout !== e.data || frame_error !== e.fe) begin
                        fails++;
                        $display("FAIL frame: dout=%h fe=%b, required dout=%h fe=%b",
                                 dout, frame_error, e.data, e.fe);
                    end
                end
            end
        end
        prev_dout = dout;
        prev_fe   = frame_error;
        prev_done = rx_done_tick && reset_n;
    end

    // Freeze monitor: on a non-tick cycle outside IDLE nothing may move
    bit          frz_en = 1'b0;
    bit          frz_have = 1'b0;
    bit          frz_tick;
    uart_state_e frz_state;
    logic [3:0]  frz_s;
    logic [2:0]  frz_n;
    logic [7:0]  frz_b;
    int          frz_checked = 0;
    int          frz_viol = 0;
    always @(negedge clk) begin
        if (frz_en && frz_have && !frz_tick && frz_state != IDLE && reset_n) begin
            frz_checked++;
            if (dut.state !== frz_state || dut.s !== frz_s || dut.n !== frz_n || dut.b !== frz_b)
                frz_viol++;
        end
        frz_have  = frz_en;
        frz_tick  = s_tick;
        frz_state = dut.state;
        frz_s     = dut.s;
        frz_n     = dut.n;
        frz_b     = dut.b;
    end

    // Serial driver: start, DBIT data bits LSB first, stop; returns with no idle gap
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input bit exp_done, output int start_cyc);
        int bit_clks;
        bit_clks = OVS * (tick_mode ? 4 : 1);
        if (exp_done) sb_q.push_back('{data: data, fe: ~stop_val});
        @(negedge clk);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < DBIT; i++) begin
            rx = data[i];
            repeat (bit_clks - 1) @(negedge clk);
            if (i < DBIT - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = stop_val;
        repeat (bit_clks - 1) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d frames outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        #12;
        tests++;
        if (dout !== 8'h00 || rx_done_tick !== 1'b0 || frame_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: dout=%h done=%b fe=%b, required 00 0 0",
                     dout, rx_done_tick, frame_error);
        end
        tests++;
        if (dut.state !== IDLE || dut.s !== 4'd0 || dut.n !== 3'd0 || dut.b !== 8'd0) begin
            fails++;
            $display("FAIL reset_state: state=%0d s=%0d n=%0d b=%h, required IDLE 0 0 00",
                     dut.state, dut.s, dut.n, dut.b);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        tests++;
        if (dut.state !== IDLE || total_done != 0) begin
            fails++;
            $display("FAIL reset_release: state=%0d dones=%0d, required IDLE 0", dut.state, total_done);
        end
    endtask

    task automatic test_basic();
        int c0, d0;
        d0 = total_done;
        send_frame(8'hA5, 1'b1, 1'b1, c0);
        wait_drain("basic", 400);
        tests++;
        if (total_done - d0 != 1) begin
            fails++;
            $display("FAIL basic_count: %0d pulses, required 1", total_done - d0);
        end else begin
            tests++;
            if (done_cyc[$] - c0 != LAT_FULL) begin
                fails++;
                $display("FAIL basic_latency: %0d clks, required %0d", done_cyc[$] - c0, LAT_FULL);
            end
        end
    endtask

    task automatic test_glitch();
        int c0, d0;
        d0 = total_done;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if (dut.state !== IDLE || total_done != d0) begin
            fails++;
            $display("FAIL glitch_reject: state=%0d pulses=%0d, required IDLE 0",
                     dut.state, total_done - d0);
        end
        send_frame(8'h3C, 1'b1, 1'b1, c0);
        wait_drain("glitch", 400);
    endtask

    task automatic test_frame_error();
        int c0;
        send_frame(8'h81, 1'b0, 1'b1, c0);
        repeat (3 * OVS) @(negedge clk);
        send_frame(8'h00, 1'b1, 1'b1, c0);
        wait_drain("frame_error", 400);
        tests++;
        if (frame_error !== 1'b0) begin
            fails++;
            $display("FAIL fe_clear: frame_error=%b, required 0", frame_error);
        end
    endtask

    task automatic test_slow_tick();
        int c0;
        tick_mode = 1'b1;
        repeat (8) @(negedge clk);
        frz_en = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b1, c0);
        wait_drain("slow_tick", 1600);
        frz_en = 1'b0;
        tests++;
        if (frz_viol != 0 || frz_checked == 0) begin
            fails++;
            $display("FAIL slow_tick_freeze: %0d changes on %0d non-tick cycles, required 0 changes",
                     frz_viol, frz_checked);
        end
        tick_mode = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int c0, d0;
        d0 = total_done;
        @(negedge clk);
        rx = 1'b0;
        repeat (OVS) @(negedge clk);
        rx = 1'b1;
        repeat (3 * OVS + OVS / 2) @(negedge clk);
        tests++;
        if (dut.state !== DATA || dut.n !== 3'd3) begin
            fails++;
            $display("FAIL abort_position: state=%0d n=%0d, required DATA 3", dut.state, dut.n);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (dout !== 8'h00 || rx_done_tick !== 1'b0 || frame_error !== 1'b0) begin
            fails++;
            $display("FAIL abort_outputs: dout=%h done=%b fe=%b, required 00 0 0",
                     dout, rx_done_tick, frame_error);
        end
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (12 * OVS) @(negedge clk);
        tests++;
        if (total_done != d0 || dut.state !== IDLE) begin
            fails++;
            $display("FAIL abort_no_pulse: pulses=%0d state=%0d, required 0 IDLE",
                     total_done - d0, dut.state);
        end
        send_frame(8'hFF, 1'b1, 1'b1, c0);
        wait_drain("abort", 400);
    endtask

    task automatic test_back_to_back();
        int c0, c1, d0;
        d0 = total_done;
        send_frame(8'h01, 1'b1, 1'b1, c0);
        send_frame(8'h80, 1'b1, 1'b1, c1);
        wait_drain("back_to_back", 600);
        tests++;
        if (total_done - d0 != 2) begin
            fails++;
            $display("FAIL b2b_count: %0d pulses, required 2", total_done - d0);
        end else begin
            tests++;
            if (done_cyc[$] - done_cyc[$-1] != 10 * OVS) begin
                fails++;
                $display("FAIL b2b_spacing: %0d clks, required %0d",
                         done_cyc[$] - done_cyc[$-1], 10 * OVS);
            end
        end
    endtask

    task automatic test_random();
        int c0;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, c0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_drain("random", 800);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_slow_tick();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
